ltc2308_reader: RTL and testbench

- SPI master for the LTC2308 12-bit ADC, clocked from the 50 MHz fabric clock.
- Free-runs conversions and alternates between single-ended channels CH0 and CH1.
- Holds the latest 12-bit result for each channel.
- Feeds the input FIFOs of the USF recovery path; `cs` doubles as the conversion strobe that downstream logic counts.

---
 rtl/ltc2308_pkg.sv | 32 +++
 rtl/ltc2308_sck_gen.sv | 50 +++++
 rtl/ltc2308_reader.sv | 125 ++++++++++++
 tb/tb_ltc2308_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// ltc2308_pkg: FSM states, LTC2308 config-word constants and default widths.
// Define LTC2308_BIPOLAR_EN to request bipolar (two's-complement) conversions.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int ADC_BITS_DEF = 12;

  // Config word is sent MSB first: S/D, O/S, S1, S0, UNI, SLP
  localparam int CFG_W   = 6;
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_UNI = 1;

`ifdef LTC2308_BIPOLAR_EN
  localparam logic CFG_UNI_VAL = 1'b0;
`else
  localparam logic CFG_UNI_VAL = 1'b1;
`endif

  localparam logic [CFG_W-1:0] CFG_CH0 = (CFG_W'(1) << CFG_SD) | (CFG_W'(CFG_UNI_VAL) << CFG_UNI);
  localparam logic [CFG_W-1:0] CFG_CH1 = CFG_CH0 | (CFG_W'(1) << CFG_OS);

  function automatic logic [CFG_W-1:0] cfg_for_ch(input logic ch);
    return ch ? CFG_CH1 : CFG_CH0;
  endfunction

endpackage

// File: rtl/ltc2308_sck_gen.sv
// ltc2308_sck_gen: SCK divider for one readout window; each bit is a low half then a high half.
// Strobes are combinational and align with the clk edge on which sck changes.
module ltc2308_sck_gen #(
  parameter int SCK_HALF = 2,
  parameter int NBITS    = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic done,
  output logic last_rise
);

  localparam int HW = $clog2(SCK_HALF) + 1;
  localparam int BW = $clog2(NBITS) + 1;

  logic [HW-1:0] half_cnt;
  logic [BW-1:0] bit_cnt;
  logic          half_end;
  logic          last_bit;

  assign half_end  = en && (half_cnt == HW'(SCK_HALF - 1));
  assign last_bit  = (bit_cnt == BW'(NBITS - 1));
  assign rise      = half_end && !sck;
  assign fall      = half_end && sck && !last_bit;
  assign done      = half_end && sck && last_bit;
  assign last_rise = rise && last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      sck      <= ~sck;
      if (sck) bit_cnt <= bit_cnt + BW'(1);
    end else begin
      half_cnt <= half_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/ltc2308_reader.sv
// ltc2308_reader: free-running LTC2308 SPI master alternating CH0/CH1 with a one-frame config pipeline.
// Build with LTC2308_BIPOLAR_EN defined to request bipolar conversions (UNI bit cleared).
module ltc2308_reader
  import ltc2308_pkg::*;
#(
  parameter int SCK_HALF    = 2,
  parameter int CONV_CYCLES = 80,
  parameter int GAP_CYCLES  = 2,
  parameter int ADC_BITS    = ADC_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  output logic                sck,
  output logic                cs,
  output logic                mosi,
  input  logic                miso,
  output logic [ADC_BITS-1:0] reading0,
  output logic [ADC_BITS-1:0] reading1,
  output logic                sample_valid,
  output logic                sample_ch
);

  localparam int CNT_MAX = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                cs_d, sck_en, cfg_load;
  logic                sck_rise, sck_fall, sck_done, last_rise;
  logic [ADC_BITS-1:0] cfg_word, cfg_sr, data_sr;
  logic                vld_p1;
  logic                next_ch, prev_ch, first_frame;

  assign cfg_word = {cfg_for_ch(next_ch), {(ADC_BITS - CFG_W){1'b0}}};

  ltc2308_sck_gen #(
    .SCK_HALF (SCK_HALF),
    .NBITS    (ADC_BITS)
  ) u_sck_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (sck_en),
    .sck       (sck),
    .rise      (sck_rise),
    .fall      (sck_fall),
    .done      (sck_done),
    .last_rise (last_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= GAP;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      GAP:     if (cnt == CNT_W'(GAP_CYCLES - 1))  state_n = CONV;
      CONV:    if (cnt == CNT_W'(CONV_CYCLES - 1)) state_n = SHIFT;
      SHIFT:   if (sck_done)                       state_n = GAP;
      default: state_n = GAP;
    endcase
  end

  // cs is registered from the next state so it changes exactly on state boundaries
  always_comb begin
    cs_d     = (state_n == CONV);
    sck_en   = (state == SHIFT);
    cfg_load = (state != SHIFT) && (state_n == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (state_n != state) cnt <= '0;
    else if (state != SHIFT)   cnt <= cnt + CNT_W'(1);
  end

  // Stage p0: serial shifters (data only, no reset)
  always_ff @(posedge clk) begin
    if (cfg_load)      cfg_sr <= cfg_word << 1;
    else if (sck_fall) cfg_sr <= cfg_sr << 1;
    if (sck_rise)      data_sr <= {data_sr[ADC_BITS-2:0], miso};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs   <= 1'b0;
      mosi <= 1'b0;
    end else begin
      cs <= cs_d;
      if (cfg_load)              mosi <= cfg_word[ADC_BITS-1];
      else if (state_n != SHIFT) mosi <= 1'b0;
      else if (sck_fall)         mosi <= cfg_sr[ADC_BITS-1];
    end
  end

  // Stage p1: result write one clk after the last sampling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      reading0     <= '0;
      reading1     <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= 1'b0;
      prev_ch      <= 1'b0;
      next_ch      <= 1'b0;
      first_frame  <= 1'b1;
    end else begin
      vld_p1       <= last_rise;
      sample_valid <= 1'b0;
      if (vld_p1) begin
        if (!first_frame) begin
          if (prev_ch) reading1 <= data_sr;
          else         reading0 <= data_sr;
          sample_valid <= 1'b1;
          sample_ch    <= prev_ch;
        end
        first_frame <= 1'b0;
        prev_ch     <= next_ch;
        next_ch     <= ~next_ch;
      end
    end
  end

endmodule

// File: tb/tb_ltc2308_reader.sv
// tb_ltc2308_reader: behavioural LTC2308 model with one-conversion config latency, scoreboard monitor.
// Honours LTC2308_BIPOLAR_EN for the expected UNI bit.
module tb_ltc2308_reader;

  localparam int SCK_HALF    = 2;
  localparam int CONV_CYCLES = 80;
  localparam int GAP_CYCLES  = 2;
`ifdef LTC2308_BIPOLAR_EN
  localparam logic UNI = 1'b0;
`else
  localparam logic UNI = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        miso;
  logic        sck, cs, mosi, sample_valid, sample_ch;
  logic [11:0] reading0, reading1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        ch;
    logic [11:0] code;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] forced0[$];
  logic [11:0] forced1[$];

  ltc2308_reader dut (
    .clk          (clk),
    .reset        (reset),
    .sck          (sck),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .reading0     (reading0),
    .reading1     (reading1),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Config word the ADC should see in frame f after reset: CH0 on even frames, CH1 on odd
  function automatic logic [11:0] cfg_ref(input int ch);
    return {1'b1, ch[0], 2'b00, UNI, 1'b0, 6'b000000};
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cs"},           32'(cs),           0);
    check({tag, "_sck"},          32'(sck),          0);
    check({tag, "_mosi"},         32'(mosi),         0);
    check({tag, "_reading0"},     32'(reading0),     0);
    check({tag, "_reading1"},     32'(reading1),     0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 0);
    check({tag, "_sample_ch"},    32'(sample_ch),    0);
  endtask

  task automatic wait_cs_rise(input int n);
    int   seen = 0;
    int   t = 0;
    logic p = cs;
    while (seen < n && t < n * 200) begin
      @(negedge clk);
      t++;
      if (cs && !p) seen++;
      p = cs;
    end
    check("cs_rise_wait", 32'(seen), 32'(n));
  endtask

  task automatic wait_cs_fall();
    int   seen = 0;
    int   t = 0;
    logic p = cs;
    while (seen < 1 && t < 200) begin
      @(negedge clk);
      t++;
      if (!cs && p) seen++;
      p = cs;
    end
    check("cs_fall_wait", 32'(seen), 1);
  endtask

  // ADC model: SDO drives the current conversion MSB-first; config captured this frame applies next conversion
  initial begin : adc_model
    logic        pcs, psck, have_cfg, cfg_ch;
    logic [11:0] code, cap;
    int          bit_idx, nbits, frame;
    exp_t        e;
    pcs = 1'b0; psck = 1'b0; have_cfg = 1'b0; cfg_ch = 1'b0;
    code = '0; cap = '0; bit_idx = -1; nbits = 0; frame = -1;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pcs = 1'b0; psck = 1'b0; have_cfg = 1'b0;
        bit_idx = -1; nbits = 0; frame = -1;
        miso = 1'b0;
        sb_q.delete();
      end else begin
        if (cs && !pcs) begin
          frame++;
          if (have_cfg) begin
            if (!cfg_ch && forced0.size() > 0)     code = forced0.pop_front();
            else if (cfg_ch && forced1.size() > 0) code = forced1.pop_front();
            else                                   code = 12'($urandom);
            e.ch   = cfg_ch;
            e.code = code;
            sb_q.push_back(e);
          end else begin
            code = 12'($urandom);
          end
        end
        if (!cs && pcs) begin
          bit_idx = 11;
          miso    = code[bit_idx];
        end
        if (sck && !psck) begin
          cap = {cap[10:0], mosi};
          nbits++;
          if (nbits == 12) begin
            check("mosi_cfg", 32'(cap), 32'(cfg_ref(frame % 2)));
            cfg_ch   = cap[10];
            have_cfg = 1'b1;
            nbits    = 0;
          end
        end
        if (!sck && psck) begin
          bit_idx--;
          miso = (bit_idx >= 0) ? code[bit_idx] : 1'b0;
        end
        pcs  = cs;
        psck = sck;
      end
    end
  end

  // Monitor: pops an expectation on each sample_valid and tracks what both readings must hold
  initial begin : monitor
    logic [11:0] ref0, ref1;
    exp_t        e;
    ref0 = '0;
    ref1 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ref0 = '0;
        ref1 = '0;
      end else begin
        if (sample_valid) begin
          check("pending_on_valid", 32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sample_ch", 32'(sample_ch), 32'(e.ch));
            if (e.ch) ref1 = e.code;
            else      ref0 = e.code;
          end
        end
        check("reading0", 32'(reading0), 32'(ref0));
        check("reading1", 32'(reading1), 32'(ref1));
      end
    end
  end

  initial begin : stim
    int   t, h, n, rises, last_n;
    logic ps;
    reset   = 1'b1;
    forced0 = '{12'hA5C, 12'hFFF, 12'h000, 12'h800};
    forced1 = '{12'h3F1, 12'h3F1, 12'h3F1};
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b0;

    t = 0;
    while (!cs && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("cs_low_clks", 32'(t), 32'(GAP_CYCLES));
    h = 0;
    while (cs && h < 200) begin
      @(negedge clk);
      h++;
    end
    check("cs_high_clks", 32'(h), 32'(CONV_CYCLES));
    n = h; rises = 0; last_n = -1; ps = sck;
    while (!cs && n < 400) begin
      if (sck && !ps) begin
        rises++;
        if (last_n >= 0) check("sck_period", 32'(n - last_n), 32'(2 * SCK_HALF));
        last_n = n;
      end
      ps = sck;
      @(negedge clk);
      n++;
    end
    check("sck_pulses", 32'(rises), 12);
    check("frame_len", 32'(n), 32'(GAP_CYCLES + CONV_CYCLES + 24 * SCK_HALF));

    wait_cs_rise(9);
    wait_cs_fall();
    repeat (48) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);

    @(posedge clk);
    #2 reset = 1'b1;
    #2 check_outputs_zero("rst2");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_cs_rise(4);
    wait_cs_fall();
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #2 check_outputs_zero("rst_mid_shift");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wait_cs_rise(6);
    wait_cs_fall();
    repeat (48) @(negedge clk);
    check("sb_drained_end", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
